// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, TX arbiter state encoding and round-robin helper.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int RR_MAX_REQ  = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } tx_arb_state_t;

    // First set bit of valid[num_req-1:0] searching upward from last+1, wrapping.
    // Returns last when nothing is valid; callers only use the result when |valid.
    function automatic logic [2:0] rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                           input logic [2:0]            last,
                                           input int unsigned           num_req);
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= RR_MAX_REQ; i++) begin
            idx = ({29'd0, last} + i) % num_req;
            if (!found && i <= num_req && valid[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running baud clock-enable: txclken is high for the cycle after the divider wraps.
module uart_baud_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic txclk,
    input  logic rst,
    output logic txclken
);

    localparam int             CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  WRAP = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge txclk) begin
        if (rst) begin
            cnt     <= '0;
            txclken <= 1'b0;
        end else if (cnt == WRAP) begin
            cnt     <= '0;
            txclken <= 1'b1;
        end else begin
            cnt     <= cnt + 1'b1;
            txclken <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Define TXARB_BURST_EN to let a granted requester send up to MAX_BURST bytes back to back.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int CLK_DIV   = 4,
    parameter int START_TO  = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                           txclk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [UART_DATA_W-1:0]         din,
    output logic                           wr_en,
    output logic                           txclken,
    input  logic                           tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           active,
    output logic                           err_timeout
);

    localparam int            GW     = $clog2(NUM_REQ);
    localparam int            TW     = (START_TO > 1) ? $clog2(START_TO) : 1;
    localparam logic [TW-1:0] TO_MAX = TW'(START_TO - 1);

    if (NUM_REQ < 2 || NUM_REQ > RR_MAX_REQ || MAX_BURST < 1) begin : g_bad_params
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and MAX_BURST >= 1");
    end

    tx_arb_state_t  state, next_state;
    logic [GW-1:0]  last_grant;
    logic [GW-1:0]  rr_grant;
    logic [GW-1:0]  pick;
    logic [TW-1:0]  to_cnt;
    logic           arb_go;
    logic           timeout_hit;

    uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .txclk   (txclk),
        .rst     (rst),
        .txclken (txclken)
    );

    assign rr_grant    = GW'(rr_pick(RR_MAX_REQ'(req_valid), 3'(last_grant), NUM_REQ));
    assign arb_go      = (state == IDLE) && !tx_busy && (|req_valid);
    assign timeout_hit = (state == WAIT_BUSY) && !tx_busy && (to_cnt == TO_MAX);

`ifdef TXARB_BURST_EN
    localparam int            BW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST - 1);

    logic [BW-1:0] burst_cnt;
    logic          burst_hold;
    logic          bursting;

    // A held burst only sticks if the owner is still asking when IDLE arbitrates.
    assign bursting = burst_hold && req_valid[grant_id];
    assign pick     = bursting ? grant_id : rr_grant;
`else
    assign pick = rr_grant;
`endif

    always_ff @(posedge txclk) begin
        if (rst) begin
            state       <= IDLE;
            active      <= 1'b0;
            din         <= '0;
            wr_en       <= 1'b0;
            grant_id    <= '0;
            err_timeout <= 1'b0;
            last_grant  <= GW'(NUM_REQ - 1);
            to_cnt      <= '0;
`ifdef TXARB_BURST_EN
            burst_cnt   <= '0;
            burst_hold  <= 1'b0;
`endif
        end else begin
            state       <= next_state;
            active      <= (next_state != IDLE);
            err_timeout <= timeout_hit;
            case (state)
                IDLE: begin
                    if (arb_go) begin
                        din      <= req_data[int'(pick)*UART_DATA_W +: UART_DATA_W];
                        grant_id <= pick;
                        wr_en    <= 1'b1;
                        to_cnt   <= '0;
`ifdef TXARB_BURST_EN
                        burst_hold <= 1'b0;
                        if (!bursting) burst_cnt <= '0;
`endif
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        wr_en <= 1'b0;
                    end else if (timeout_hit) begin
                        // Dropped byte still counts as this requester's turn.
                        wr_en      <= 1'b0;
                        last_grant <= grant_id;
`ifdef TXARB_BURST_EN
                        burst_cnt  <= '0;
                        burst_hold <= 1'b0;
`endif
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        last_grant <= grant_id;
`ifdef TXARB_BURST_EN
                        if (req_valid[grant_id] && burst_cnt < BURST_MAX) begin
                            burst_hold <= 1'b1;
                            burst_cnt  <= burst_cnt + 1'b1;
                        end else begin
                            burst_hold <= 1'b0;
                            burst_cnt  <= '0;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: next_state gets a default before the case so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (arb_go) next_state = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy)          next_state = WAIT_DONE;
                else if (timeout_hit) next_state = IDLE;
            end
            WAIT_DONE: if (!tx_busy) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (arb_go) req_ready[pick] = 1'b1;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transmitter model plus a transaction-level
// round-robin reference model; covers both TXARB_BURST_EN builds.
module tb_uart_tx_arbiter;

    localparam int N         = 4;
    localparam int CLK_DIV   = 4;
    localparam int START_TO  = 16;
    localparam int MAX_BURST = 4;
    localparam int BUSY_LEN  = 40;
`ifdef TXARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic           txclk = 1'b0;
    logic           rst   = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_data  = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     din;
    logic           wr_en;
    logic           txclken;
    logic           tx_busy = 1'b0;
    logic [1:0]     grant_id;
    logic           active;
    logic           err_timeout;

    // Second instance only exercises the CLK_DIV=1 baud path; its arbiter stays idle.
    logic [1:0]     req_valid2 = '0;
    logic [15:0]    req_data2  = '0;
    logic           tx_busy2   = 1'b0;
    logic [1:0]     req_ready2;
    logic [7:0]     din2;
    logic           wr_en2;
    logic           txclken1;
    logic [0:0]     grant_id2;
    logic           active2;
    logic           err2;

    uart_tx_arbiter #(.NUM_REQ(N), .CLK_DIV(CLK_DIV), .START_TO(START_TO), .MAX_BURST(MAX_BURST)) dut (
        .txclk(txclk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .din(din), .wr_en(wr_en), .txclken(txclken),
        .tx_busy(tx_busy), .grant_id(grant_id), .active(active), .err_timeout(err_timeout)
    );

    uart_tx_arbiter #(.NUM_REQ(2), .CLK_DIV(1), .START_TO(START_TO), .MAX_BURST(MAX_BURST)) dut_div1 (
        .txclk(txclk), .rst(rst), .req_valid(req_valid2), .req_data(req_data2),
        .req_ready(req_ready2), .din(din2), .wr_en(wr_en2), .txclken(txclken1),
        .tx_busy(tx_busy2), .grant_id(grant_id2), .active(active2), .err_timeout(err2)
    );

    always #5 txclk = ~txclk;

    int checks = 0;
    int errors = 0;

    // Reference model state: whose turn it was last, and burst bookkeeping.
    int m_last     = N - 1;
    int m_cnt      = 0;
    bit m_burst_ok = 1'b0;

    // Transmitter model: busy BUSY_LEN cycles, rising two cycles after wr_en.
    bit xm_en   = 1'b1;
    int xm_st   = 0;
    int xm_left = 0;

    int         grants       = 0;
    bit         prev_granted = 1'b0;
    logic [7:0] exp_din      = '0;
    int         exp_gid      = 0;
    int         obs_q[$];
    logic [7:0] obs_d[$];

    function automatic int model_pick(input logic [N-1:0] v, output bit burst);
        int idx;
        burst = 1'b0;
        if (BURST && m_burst_ok && v[m_last] && m_cnt < MAX_BURST - 1) begin
            burst = 1'b1;
            return m_last;
        end
        for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last     = N - 1;
        m_cnt      = 0;
        m_burst_ok = 1'b0;
    endtask

    task automatic step();
        logic [N-1:0] rr, exp_rr;
        int           pick, seen;
        bit           granted, burst;
        granted = 1'b0;
        @(negedge txclk);
        rr = req_ready;
        if (!rst) begin
            if (prev_granted) begin
                checks++;
                if (rr !== '0) begin
                    errors++;
                    $display("FAIL ready_after_grant: got %b expected 0", rr);
                end
            end
            if (rr !== '0) begin
                pick   = model_pick(req_valid, burst);
                exp_rr = '0;
                if (pick >= 0) exp_rr[pick] = 1'b1;
                checks++;
                if (rr !== exp_rr) begin
                    errors++;
                    $display("FAIL req_ready: got %b expected %b (valid %b)", rr, exp_rr, req_valid);
                end
                seen = -1;
                for (int i = N - 1; i >= 0; i--) if (rr[i]) seen = i;
                if (pick >= 0) begin
                    exp_din = req_data[pick*8 +: 8];
                    exp_gid = pick;
                    m_cnt   = burst ? m_cnt + 1 : 0;
                    m_last  = pick;
                    m_burst_ok = 1'b1;
                end
                obs_q.push_back(seen);
                grants++;
                granted = 1'b1;
            end
        end
        @(posedge txclk);
        #1;
        if (granted) begin
            checks++;
            if (wr_en !== 1'b1 || din !== exp_din || grant_id !== 2'(exp_gid) || active !== 1'b1) begin
                errors++;
                $display("FAIL accept_out: got wr_en=%b din=%h gid=%0d act=%b expected 1 %h %0d 1",
                         wr_en, din, grant_id, active, exp_din, exp_gid);
            end
            obs_d.push_back(din);
        end else if (!rst && wr_en === 1'b1) begin
            checks++;
            if (din !== exp_din) begin
                errors++;
                $display("FAIL din_hold: got %h expected %h", din, exp_din);
            end
        end
        prev_granted = granted;
        if (xm_st == 0) begin
            if (wr_en === 1'b1 && xm_en) xm_st = 1;
        end else if (xm_st == 1) begin
            tx_busy = 1'b1;
            xm_left = BUSY_LEN;
            xm_st   = 2;
        end else begin
            xm_left--;
            if (xm_left == 0) begin
                tx_busy = 1'b0;
                xm_st   = 0;
            end
        end
        #1;
    endtask

    task automatic run_grants(input int n, input int budget);
        int target, cyc;
        target = grants + n;
        cyc    = 0;
        while (grants < target && cyc < budget) begin
            step();
            cyc++;
        end
        checks++;
        if (grants < target) begin
            errors++;
            $display("FAIL grant_budget: got %0d grants expected %0d", grants, target);
        end
    endtask

    task automatic wait_idle(input int budget);
        int cyc;
        cyc = 0;
        while ((active === 1'b1 || tx_busy || wr_en === 1'b1) && cyc < budget) begin
            step();
            cyc++;
        end
        checks++;
        if (active !== 1'b0 || tx_busy) begin
            errors++;
            $display("FAIL idle_budget: got active=%b busy=%b expected 0 0", active, tx_busy);
        end
    endtask

    task automatic do_reset();
        int guard;
        req_valid = '0;
        guard = 0;
        while (tx_busy && guard < 200) begin
            step();
            guard++;
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_reset();
        prev_granted = 1'b0;
        obs_q.delete();
        obs_d.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (3) step();
        checks++;
        if (wr_en !== 1'b0 || din !== 8'h00 || grant_id !== 2'd0 || active !== 1'b0 ||
            err_timeout !== 1'b0 || txclken !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL reset_vals: got wr=%b din=%h gid=%0d act=%b err=%b clken=%b rdy=%b expected all 0",
                     wr_en, din, grant_id, active, err_timeout, txclken, req_ready);
        end
        checks++;
        if (txclken1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_clken_div1: got %b expected 0", txclken1);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0001;
        req_data  = {24'h5a5a5a, 8'h63};
        run_grants(1, 1);
        req_valid = '0;
        checks++;
        if (obs_q.size() != 1 || obs_q[0] != 0 || din !== 8'h63 || wr_en !== 1'b1 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL single: got din=%h wr=%b gid=%0d expected 63 1 0", din, wr_en, grant_id);
        end
        wait_idle(200);
    endtask

    task automatic test_round_robin();
        int exp_idx[5] = '{0, 1, 2, 3, 0};
        do_reset();
        req_valid = 4'b1111;
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        run_grants(5, 400);
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (k >= obs_q.size() || obs_q[k] != exp_idx[k] || obs_d[k] !== 8'(8'hA0 + exp_idx[k])) begin
                errors++;
                $display("FAIL rr_order[%0d]: got idx %0d expected %0d", k,
                         (k < obs_q.size()) ? obs_q[k] : -1, exp_idx[k]);
            end
        end
        wait_idle(200);
    endtask

    task automatic test_timeout();
        int hi, pulses;
        do_reset();
        xm_en     = 1'b0;
        req_valid = 4'b0001;
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        run_grants(1, 2);
        req_valid = '0;
        hi = (wr_en === 1'b1) ? 1 : 0;
        pulses = 0;
        repeat (30) begin
            step();
            if (wr_en === 1'b1) hi++;
            if (err_timeout === 1'b1) pulses++;
        end
        checks++;
        if (hi != START_TO) begin
            errors++;
            $display("FAIL timeout_wr_en_len: got %0d expected %0d", hi, START_TO);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL timeout_pulse: got %0d expected 1", pulses);
        end
        m_burst_ok = 1'b0;
        m_cnt      = 0;
        xm_en      = 1'b1;
        req_valid  = 4'b0011;
        run_grants(1, 4);
        req_valid  = '0;
        checks++;
        if (obs_q.size() < 2 || obs_q[obs_q.size()-1] != 1) begin
            errors++;
            $display("FAIL timeout_next: got %0d expected 1", (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : -1);
        end
        wait_idle(200);
    endtask

    task automatic test_reset_mid_frame();
        int guard;
        do_reset();
        req_valid = 4'b0010;
        req_data  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        run_grants(1, 2);
        req_valid = '0;
        guard = 0;
        while (!(tx_busy && wr_en === 1'b0) && guard < 20) begin
            step();
            guard++;
        end
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        prev_granted = 1'b0;
        req_valid = 4'b0011;
        checks++;
        if (!tx_busy) begin
            errors++;
            $display("FAIL rst_mid_busy: got tx_busy=0 expected 1");
        end
        guard = 0;
        while (tx_busy && guard < 60) begin
            checks++;
            if (req_ready !== '0 || wr_en !== 1'b0 || active !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_hold: got rdy=%b wr=%b act=%b expected 0 0 0", req_ready, wr_en, active);
            end
            step();
            guard++;
        end
        run_grants(1, 4);
        req_valid = '0;
        checks++;
        if (obs_q.size() < 2 || obs_q[obs_q.size()-1] != 0) begin
            errors++;
            $display("FAIL rst_mid_next: got %0d expected 0", (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : -1);
        end
        wait_idle(200);
    endtask

    task automatic test_baud();
        int guard;
        guard = 0;
        while (txclken !== 1'b1 && guard < 8) begin
            step();
            guard++;
        end
        for (int k = 1; k <= 11; k++) begin
            step();
            checks++;
            if (txclken !== ((k % CLK_DIV) == 0)) begin
                errors++;
                $display("FAIL txclken[%0d]: got %b expected %b", k, txclken, (k % CLK_DIV) == 0);
            end
            checks++;
            if (txclken1 !== 1'b1) begin
                errors++;
                $display("FAIL txclken_div1[%0d]: got %b expected 1", k, txclken1);
            end
        end
        checks++;
        if (wr_en2 !== 1'b0 || active2 !== 1'b0 || req_ready2 !== '0 || err2 !== 1'b0 ||
            din2 !== 8'h00 || grant_id2 !== 1'b0) begin
            errors++;
            $display("FAIL div1_idle: got wr=%b act=%b rdy=%b err=%b din=%h gid=%0d expected reset values",
                     wr_en2, active2, req_ready2, err2, din2, grant_id2);
        end
    endtask

    task automatic test_burst();
`ifdef TXARB_BURST_EN
        int exp_seq[$] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
`else
        int exp_seq[$] = '{0, 1, 0, 1};
`endif
        do_reset();
        req_valid = 4'b0011;
        req_data  = {8'h00, 8'h00, 8'h11, 8'h10};
        run_grants(exp_seq.size(), 700);
        req_valid = '0;
        foreach (exp_seq[k]) begin
            checks++;
            if (k >= obs_q.size() || obs_q[k] != exp_seq[k]) begin
                errors++;
                $display("FAIL burst_seq[%0d]: got %0d expected %0d", k,
                         (k < obs_q.size()) ? obs_q[k] : -1, exp_seq[k]);
            end
        end
        wait_idle(200);
    endtask

    task automatic test_random();
        do_reset();
        req_valid = 4'($urandom_range(1, 15));
        req_data  = $urandom;
        for (int t = 0; t < 24; t++) begin
            run_grants(1, 120);
            req_valid = 4'($urandom_range(1, 15));
            req_data  = $urandom;
        end
        req_valid = '0;
        wait_idle(200);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_reset_mid_frame();
        test_baud();
        test_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
